// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the 9-bit processor fetch/sequencing controller.
package prog_sequencer_pkg;

    localparam int MODE_W = 2;

    localparam logic [2:0] OP_SET  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        STALL,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_LOAD,
        PC_CLEAR
    } pc_op_t;

endpackage

// File: rtl/prog_sequencer_counter.sv
// Program counter register with hold / increment / absolute load / clear select.
module prog_counter
    import prog_sequencer_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_op_t          pc_op,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    // Increment wraps naturally at 2^PC_W; the target is taken as-is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else begin
            case (pc_op)
                PC_INC:   pc <= pc + PC_W'(1);
                PC_LOAD:  pc <= target;
                PC_CLEAR: pc <= '0;
                default:  pc <= pc;
            endcase
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Fetch/sequencing controller: PC, mode selector, start/done handshake and memory stalls.
// Optional CycleCount output enabled by defining PROG_SEQUENCER_CYCLE_COUNT_EN.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int MEM_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic [8:0]        Instruction,
    input  logic              MemAccess,
    input  logic              BranchEn,
    input  logic              Taken,
    input  logic [PC_W-1:0]   BranchTarget,
    output logic [PC_W-1:0]   ProgCounter,
    output logic [MODE_W-1:0] Mode,
    output logic              InstrValid,
    output logic              Done
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    ,
    output logic [15:0]       CycleCount
`endif
);

    // The counter only ever holds MEM_LAT-1 down to 0.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] STALL_INIT = (MEM_LAT > 0) ? CNT_W'(MEM_LAT - 1) : '0;
    localparam bit HAS_STALL = (MEM_LAT > 0);

    seq_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [MODE_W-1:0] mode_nxt;
    logic              done_nxt;
    pc_op_t            pc_op;

    logic [2:0] opcode;
    logic       is_halt, is_set, mem_stall;
    logic       unused_instr;

    assign opcode       = Instruction[8:6];
    assign is_halt      = (opcode == OP_HALT);
    assign is_set       = (opcode == OP_SET);
    assign mem_stall    = HAS_STALL && MemAccess && !is_halt && !is_set;
    assign unused_instr = ^Instruction[5:2];

    prog_counter #(
        .PC_W (PC_W)
    ) u_pc (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .pc_op  (pc_op),
        .target (BranchTarget),
        .pc     (ProgCounter)
    );

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mode_nxt   = Mode;
        done_nxt   = Done;
        pc_op      = PC_HOLD;
        InstrValid = 1'b0;

        case (state)
            IDLE: if (Start) state_nxt = ARM;
            ARM:  if (!Start) state_nxt = RUN;
            RUN: begin
                InstrValid = !mem_stall;
                if (is_halt) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (is_set) begin
                    mode_nxt = Instruction[MODE_W-1:0];
                    pc_op    = PC_INC;
                end else if (mem_stall) begin
                    cnt_nxt   = STALL_INIT;
                    state_nxt = STALL;
                end else if (BranchEn && Taken) begin
                    pc_op = PC_LOAD;
                end else begin
                    pc_op = PC_INC;
                end
            end
            STALL: begin
                if (cnt == '0) begin
                    InstrValid = 1'b1;
                    pc_op      = PC_INC;
                    state_nxt  = RUN;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DONE:    ;
            default: state_nxt = IDLE;
        endcase

        // Start restarts from any state, including mid-stall.
        if (Start) begin
            state_nxt = ARM;
            cnt_nxt   = '0;
            mode_nxt  = '0;
            done_nxt  = 1'b0;
            pc_op     = PC_CLEAR;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            Mode  <= '0;
            Done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            Mode  <= mode_nxt;
            Done  <= done_nxt;
        end
    end

`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            CycleCount <= '0;
        end else if (Start) begin
            CycleCount <= '0;
        end else if ((state == RUN || state == STALL) && CycleCount != 16'hFFFF) begin
            CycleCount <= CycleCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed plus randomized bench for prog_sequencer against a behavioural program-flow model.
module tb_prog_sequencer;

    localparam int PC_W    = 6;
    localparam int MEM_LAT = 2;
    localparam int PC_MOD  = 1 << PC_W;

    localparam logic [8:0] I_ALU  = 9'b000_000_000;
    localparam logic [8:0] I_HALT = 9'b111_000_000;

    logic            Clk = 1'b0;
    logic            Reset_n = 1'b1;
    logic            Start = 1'b0;
    logic [8:0]      Instruction = '0;
    logic            MemAccess = 1'b0;
    logic            BranchEn = 1'b0;
    logic            Taken = 1'b0;
    logic [PC_W-1:0] BranchTarget = '0;
    logic [PC_W-1:0] ProgCounter;
    logic [1:0]      Mode;
    logic            InstrValid;
    logic            Done;
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
    logic [15:0]     CycleCount;
`endif

    prog_sequencer #(
        .PC_W    (PC_W),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start        (Start),
        .Instruction  (Instruction),
        .MemAccess    (MemAccess),
        .BranchEn     (BranchEn),
        .Taken        (Taken),
        .BranchTarget (BranchTarget),
        .ProgCounter  (ProgCounter),
        .Mode         (Mode),
        .InstrValid   (InstrValid),
        .Done         (Done)
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
        ,
        .CycleCount   (CycleCount)
`endif
    );

    always #5 Clk = ~Clk;

    // Program-flow model: armed / running / halted flags, plus how many
    // cycles of the current memory instruction have already elapsed.
    bit m_arm, m_run, m_halt;
    int m_memcyc, m_pc, m_mode, m_done, m_cc;
    int n_assert = 0;
    int n_fail   = 0;
    int iv_seen  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_arm = 0; m_run = 0; m_halt = 0;
        m_memcyc = 0; m_pc = 0; m_mode = 0; m_done = 0; m_cc = 0;
    endtask

    function automatic bit model_iv();
        if (!m_run)            return 1'b0;
        if (m_memcyc > 0)      return (m_memcyc == MEM_LAT);
        if (Instruction[8:7] == 2'b11) return 1'b1;
        return !(MemAccess && MEM_LAT > 0);
    endfunction

    task automatic model_step();
        if (Start)                     m_cc = 0;
        else if (m_run && m_cc < 65535) m_cc++;
        if (Start) begin
            m_arm = 1; m_run = 0; m_halt = 0;
            m_pc = 0; m_mode = 0; m_done = 0; m_memcyc = 0;
        end else if (m_arm) begin
            m_arm = 0; m_run = 1;
        end else if (m_run) begin
            if (m_memcyc > 0) begin
                if (m_memcyc == MEM_LAT) begin
                    m_pc = (m_pc + 1) % PC_MOD;
                    m_memcyc = 0;
                end else begin
                    m_memcyc++;
                end
            end else if (Instruction[8:6] == 3'b111) begin
                m_run = 0; m_halt = 1; m_done = 1;
            end else if (Instruction[8:6] == 3'b110) begin
                m_mode = int'(Instruction[1:0]);
                m_pc = (m_pc + 1) % PC_MOD;
            end else if (MemAccess && MEM_LAT > 0) begin
                m_memcyc = 1;
            end else if (BranchEn && Taken) begin
                m_pc = int'(BranchTarget);
            end else begin
                m_pc = (m_pc + 1) % PC_MOD;
            end
        end
    endtask

    task automatic cycle(input bit st, input logic [8:0] ins, input bit mem,
                         input bit br, input bit tk, input int tgt);
        Start = st; Instruction = ins; MemAccess = mem;
        BranchEn = br; Taken = tk; BranchTarget = PC_W'(tgt);
        @(negedge Clk);
        chk("InstrValid", 32'(InstrValid), 32'(model_iv()));
        if (InstrValid) iv_seen++;
        @(posedge Clk);
        model_step();
        #1;
        chk("ProgCounter", 32'(ProgCounter), 32'(m_pc));
        chk("Mode", 32'(Mode), 32'(m_mode));
        chk("Done", 32'(Done), 32'(m_done));
`ifdef PROG_SEQUENCER_CYCLE_COUNT_EN
        chk("CycleCount", 32'(CycleCount), 32'(m_cc));
`endif
    endtask

    task automatic run_alu();
        cycle(0, I_ALU, 0, 0, 0, 0);
    endtask

    task automatic jump(input int tgt);
        cycle(0, I_ALU, 0, 1, 1, tgt);
    endtask

    task automatic start_seq();
        for (int i = 0; i < 3; i++) cycle(1, I_ALU, 0, 0, 0, 0);
        cycle(0, I_ALU, 0, 0, 0, 0);
    endtask

    initial begin
        logic [8:0] rins;
        int         r;

        model_reset();
        #1 Reset_n = 1'b0;
        #1;
        chk("reset_pc", 32'(ProgCounter), 32'd0);
        chk("reset_mode", 32'(Mode), 32'd0);
        chk("reset_done", 32'(Done), 32'd0);
        chk("reset_iv", 32'(InstrValid), 32'd0);
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk);
        #1;

        run_alu();
        run_alu();

        // set S=01, ALU op, halt
        start_seq();
        iv_seen = 0;
        cycle(0, 9'b110_000_001, 0, 0, 0, 0);
        run_alu();
        cycle(0, I_HALT, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 9'b110_000_011, 1, 1, 1, 9);
        chk("program_iv_pulses", 32'(iv_seen), 32'd3);

        // load at PC=5
        start_seq();
        jump(5);
        iv_seen = 0;
        for (int i = 0; i < 3; i++) cycle(0, I_ALU, 1, 0, 0, 0);
        chk("load_iv_pulses", 32'(iv_seen), 32'd1);
        run_alu();

        // branch at PC=10 taken / not taken
        jump(10);
        cycle(0, I_ALU, 0, 1, 1, 3);
        jump(10);
        cycle(0, I_ALU, 0, 1, 0, 3);
        cycle(0, I_ALU, 0, 0, 1, 20);

        // wrap at top of ROM, then halt overriding branch and memory
        jump(PC_MOD - 1);
        run_alu();
        cycle(0, I_HALT, 1, 1, 1, 20);
        run_alu();

        // Start during a stall
        start_seq();
        jump(8);
        iv_seen = 0;
        cycle(0, I_ALU, 1, 0, 0, 0);
        cycle(1, I_ALU, 1, 0, 0, 0);
        cycle(0, I_ALU, 1, 0, 0, 0);
        chk("abort_iv_pulses", 32'(iv_seen), 32'd0);

        // randomized program flow
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 15));
            if (r == 0)      rins[8:6] = 3'b111;
            else if (r < 3)  rins[8:6] = 3'b110;
            else             rins[8:6] = 3'($urandom_range(0, 5));
            rins[5:0] = 6'($urandom);
            cycle($urandom_range(0, 39) == 0, rins, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom), int'($urandom_range(0, PC_MOD - 1)));
        end

        // async reset mid-run at PC=37
        start_seq();
        cycle(0, 9'b110_000_011, 0, 0, 0, 0);
        jump(37);
        Start = 0; Instruction = I_ALU; MemAccess = 0; BranchEn = 0; Taken = 0;
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("midrun_reset_pc", 32'(ProgCounter), 32'd0);
        chk("midrun_reset_mode", 32'(Mode), 32'd0);
        chk("midrun_reset_done", 32'(Done), 32'd0);
        chk("midrun_reset_iv", 32'(InstrValid), 32'd0);
        @(negedge Clk) Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 4; i++) cycle(0, 9'b110_000_010, 0, 1, 1, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
